// File: rtl/mem_xfer_seq.sv
// Memory-side transfer sequencer for the 16-bit bus.
// Splits fetches into two beats and steers the IR/MDR capture strobes.
module mem_xfer_seq #(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 15,
    parameter int TO_W        = 4
) (
    input  logic              Fclk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ack,
    output logic              IRWr1,
    output logic              IRWr0,
    output logic              mdr_load,
    output logic              MemWrite,
    output logic              done,
    output logic              err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_HI,
        S_IF_LO,
        S_LD,
        S_ST,
        S_BAD
    } state_t;

    state_t            state;
    logic [TO_W-1:0]   cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              to_hit;
    logic              in_beat;

    assign to_hit  = (TIMEOUT_CYC != 0) && (cnt == TO_W'(TIMEOUT_CYC));
    assign in_beat = (state == S_IF_HI) || (state == S_IF_LO)
                   || (state == S_LD) || (state == S_ST);

    // Sequencer state, beat timeout counter and completion pulses
    always_ff @(posedge Fclk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        cnt    <= '0;
                        case (req_op)
                            2'b00:   state <= S_IF_HI;
                            2'b01:   state <= S_LD;
                            2'b10:   state <= S_ST;
                            default: state <= S_BAD;
                        endcase
                    end
                end
                S_IF_HI, S_IF_LO, S_LD, S_ST: begin
                    // An ack arriving on the timeout cycle still completes the beat
                    if (mem_ack) begin
                        cnt <= '0;
                        if (state == S_IF_HI) begin
                            state <= S_IF_LO;
                        end else begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end else if (to_hit) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                S_BAD: begin
                    state <= S_IDLE;
                    err   <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus strobes decode from state; capture strobes also need the ack
    always_comb begin
        mem_addr = '0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        MemWrite = 1'b0;
        IRWr1    = 1'b0;
        IRWr0    = 1'b0;
        mdr_load = 1'b0;
        case (state)
            S_IF_HI: begin
                mem_addr = addr_q;
                mem_rd   = 1'b1;
                IRWr1    = mem_ack;
            end
            S_IF_LO: begin
                mem_addr = addr_q + ADDR_W'(1);
                mem_rd   = 1'b1;
                IRWr0    = mem_ack;
            end
            S_LD: begin
                mem_addr = addr_q;
                mem_rd   = 1'b1;
                mdr_load = mem_ack;
            end
            S_ST: begin
                mem_addr = addr_q;
                mem_wr   = 1'b1;
                MemWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = ~req_ready;

    logic unused_beat;
    assign unused_beat = in_beat;

endmodule
